// File: rtl/astar_grid_renderer.sv
// Cell-state map and per-pixel renderer for the A* search display.
// Two-cycle pixel pipeline with matching sync delay and a map clear engine.
module astar_grid_renderer #(
  parameter int GRID_N  = 40,
  parameter int CELL_PX = 12,
  parameter int X_OFF   = 80,
  parameter int Y_OFF   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [1:0] wr_type,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [5:0] gridx,
  output logic [5:0] gridy,
  output logic       draw_grid,
  output logic       draw_obstacle,
  output logic       draw_path,
  output logic       draw_unknown,
  output logic [7:0] rgb
);

  localparam int DEPTH = GRID_N * GRID_N;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(CELL_PX);

  localparam logic [9:0]    X_LO    = 10'(X_OFF);
  localparam logic [9:0]    Y_LO    = 10'(Y_OFF);
  localparam logic [9:0]    SPAN    = 10'(GRID_N * CELL_PX);
  localparam logic [PW-1:0] PX_LAST = PW'(CELL_PX - 1);
  localparam logic [AW-1:0] A_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] N_A     = AW'(GRID_N);
  localparam logic [5:0]    N_6     = 6'(GRID_N);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            wr_ready_q, clear_busy_q;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [1:0]      mem_wdata;
  logic [AW-1:0]   raddr;
  logic [1:0]      mem [DEPTH];
  logic [1:0]      rd_q;

  logic [PW-1:0]   px_cnt_q, px_cnt_d;
  logic [PW-1:0]   row_px_q, row_px_d;
  logic [5:0]      col_q, col_d;
  logic [5:0]      row_q, row_d;
  logic [9:0]      hrel, vrel;
  logic            in_grid_q, in_grid_d;
  logic            hs1_q, vs1_q;
  logic            border;

  logic [5:0]      gridx_q, gridx_d;
  logic [5:0]      gridy_q, gridy_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            dg_q, dg_d;
  logic            do_q, do_d;
  logic            dp_q, dp_d;
  logic            du_q, du_d;
  logic            hs2_q, vs2_q;

  // Clear engine walks every address once, then hands the port to writers
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_addr_q == A_LAST) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  // Control state with registered handshake/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      wr_ready_q   <= 1'b0;
      clear_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      wr_ready_q   <= (state_d == S_IDLE);
      clear_busy_q <= (state_d == S_CLEAR);
    end
  end

  // Write port mux: clear engine owns it while clearing, else the handshake
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = 2'd0;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (wr_valid && (wr_x < N_6) && (wr_y < N_6)) begin
      mem_we    = 1'b1;
      mem_waddr = AW'(wr_y) * N_A + AW'(wr_x);
      mem_wdata = wr_type;
    end
  end

  // Incremental cell tracking so no divider is needed on hcount/vcount
  always_comb begin
    px_cnt_d = px_cnt_q + 1'b1;
    col_d    = col_q;
    if (hcount == X_LO) begin
      px_cnt_d = '0;
      col_d    = '0;
    end else if (px_cnt_q == PX_LAST) begin
      px_cnt_d = '0;
      col_d    = col_q + 1'b1;
    end
    row_px_d = row_px_q;
    row_d    = row_q;
    if (hcount == 10'd0) begin
      if (vcount == Y_LO) begin
        row_px_d = '0;
        row_d    = '0;
      end else if (row_px_q == PX_LAST) begin
        row_px_d = '0;
        row_d    = row_q + 1'b1;
      end else begin
        row_px_d = row_px_q + 1'b1;
      end
    end
    hrel      = hcount - X_LO;
    vrel      = vcount - Y_LO;
    in_grid_d = video_on && (hrel < SPAN) && (vrel < SPAN);
    raddr     = in_grid_d ? (AW'(row_d) * N_A + AW'(col_d)) : '0;
  end

  // Map storage: read returns the pre-write value on a same-cell collision
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_q <= mem[raddr];
  end

  // Stage 1: coordinates, visibility and first sync delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_cnt_q  <= '0;
      row_px_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      in_grid_q <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
    end else begin
      px_cnt_q  <= px_cnt_d;
      row_px_q  <= row_px_d;
      col_q     <= col_d;
      row_q     <= row_d;
      in_grid_q <= in_grid_d;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
    end
  end

  assign border = (px_cnt_q == '0) || (row_px_q == '0);

  // Pixel classification: border wins, then the cell contents
  always_comb begin
    gridx_d = gridx_q;
    gridy_d = gridy_q;
    rgb_d   = 8'h00;
    dg_d    = 1'b0;
    do_d    = 1'b0;
    dp_d    = 1'b0;
    du_d    = 1'b0;
    if (in_grid_q) begin
      gridx_d = col_q;
      gridy_d = row_q;
      if (border) begin
        dg_d  = 1'b1;
        rgb_d = 8'h49;
      end else begin
        unique case (rd_q)
          2'd1: begin do_d = 1'b1; rgb_d = 8'hE0; end
          2'd2: begin dp_d = 1'b1; rgb_d = 8'h1C; end
          2'd3: rgb_d = 8'h03;
          default: du_d = 1'b1;
        endcase
      end
    end
  end

  // Stage 2: registered pixel outputs and second sync delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gridx_q <= '0;
      gridy_q <= '0;
      rgb_q   <= '0;
      dg_q    <= 1'b0;
      do_q    <= 1'b0;
      dp_q    <= 1'b0;
      du_q    <= 1'b0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
    end else begin
      gridx_q <= gridx_d;
      gridy_q <= gridy_d;
      rgb_q   <= rgb_d;
      dg_q    <= dg_d;
      do_q    <= do_d;
      dp_q    <= dp_d;
      du_q    <= du_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign clear_busy    = clear_busy_q;
  assign hsync_out     = hs2_q;
  assign vsync_out     = vs2_q;
  assign gridx         = gridx_q;
  assign gridy         = gridy_q;
  assign rgb           = rgb_q;
  assign draw_grid     = dg_q;
  assign draw_obstacle = do_q;
  assign draw_path     = dp_q;
  assign draw_unknown  = du_q;

endmodule

// File: tb/tb_astar_grid_renderer.sv
// Randomized bench for astar_grid_renderer.
// Behavioural map/pixel model with per-cycle compare and literal anchors.
module tb_astar_grid_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hcount = 10'd700;
  logic [9:0] vcount = 10'd600;
  logic       video_on = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [5:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [1:0] wr_type = '0;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic       hsync_out, vsync_out;
  logic [5:0] gridx, gridy;
  logic       draw_grid, draw_obstacle, draw_path, draw_unknown;
  logic [7:0] rgb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  astar_grid_renderer dut (
    .clk(clk), .reset(reset),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .gridx(gridx), .gridy(gridy),
    .draw_grid(draw_grid), .draw_obstacle(draw_obstacle),
    .draw_path(draw_path), .draw_unknown(draw_unknown),
    .rgb(rgb)
  );

  typedef struct {
    bit ing;
    int gx;
    int gy;
    int rgb;
    int flags;
    bit hs;
    bit vs;
    int hc;
    int vc;
  } px_t;

  int  mmap [1600];
  bit  m_clear;
  int  m_left;
  px_t p1, po, rst_px;
  bit  wr_rand = 0;
  bit  oob_rand = 0;
  int  lit_rgb = 0;
  int  lit_flag = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // flags packed as {grid, obstacle, path, unknown}
  function automatic px_t eval_px();
    px_t e;
    int hx, vy, t;
    hx = int'(hcount) - 80;
    vy = int'(vcount);
    e.hc = int'(hcount);
    e.vc = int'(vcount);
    e.hs = hsync_in;
    e.vs = vsync_in;
    e.ing = video_on && hx >= 0 && hx < 480 && vy < 480;
    e.gx = 0; e.gy = 0; e.rgb = 0; e.flags = 0;
    if (e.ing) begin
      e.gx = hx / 12;
      e.gy = vy / 12;
      t = mmap[e.gy * 40 + e.gx];
      if (hx % 12 == 0 || vy % 12 == 0) begin
        e.flags = 8; e.rgb = 'h49;
      end else if (t == 1) begin
        e.flags = 4; e.rgb = 'hE0;
      end else if (t == 2) begin
        e.flags = 2; e.rgb = 'h1C;
      end else if (t == 3) begin
        e.flags = 0; e.rgb = 'h03;
      end else begin
        e.flags = 1; e.rgb = 0;
      end
    end
    return e;
  endfunction

  // reference model, advanced on every rising edge
  initial begin
    rst_px = '{ing: 0, gx: 0, gy: 0, rgb: 0, flags: 0,
               hs: 1, vs: 1, hc: -1, vc: -1};
    forever begin
      @(posedge clk);
      if (reset) begin
        m_clear = 1; m_left = 1600;
        p1 = rst_px; po = rst_px;
      end else begin
        px_t e, n;
        e = eval_px();
        n = p1;
        if (!n.ing) begin
          n.gx = po.gx; n.gy = po.gy;
        end
        po = n;
        p1 = e;
        if (m_clear) begin
          mmap[1600 - m_left] = 0;
          m_left--;
          if (m_left == 0) m_clear = 0;
        end else begin
          if (wr_valid && wr_x < 40 && wr_y < 40)
            mmap[int'(wr_y) * 40 + int'(wr_x)] = int'(wr_type);
          if (clear_req) begin
            m_clear = 1; m_left = 1600;
          end
        end
      end
    end
  end

  // compare process on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      begin
        px_t x;
        int fl;
        x = reset ? rst_px : po;
        fl = {28'd0, draw_grid, draw_obstacle, draw_path, draw_unknown};
        chk("rgb", int'(rgb), x.rgb);
        chk("gridx", int'(gridx), x.gx);
        chk("gridy", int'(gridy), x.gy);
        chk("draw_flags", fl, x.flags);
        chk("hsync_out", int'(hsync_out), int'(x.hs));
        chk("vsync_out", int'(vsync_out), int'(x.vs));
        chk("wr_ready", int'(wr_ready), reset ? 0 : int'(!m_clear));
        chk("clear_busy", int'(clear_busy), reset ? 1 : int'(m_clear));
        if (!reset && x.vc == 66 && x.hc == 122) begin
          chk("lit_gx", int'(gridx), 3);
          chk("lit_gy", int'(gridy), 5);
          chk("lit_cell_rgb", int'(rgb), lit_rgb);
          chk("lit_cell_obs", int'(draw_obstacle), int'(lit_flag == 1));
          chk("lit_cell_path", int'(draw_path), int'(lit_flag == 2));
          chk("lit_cell_free", int'(draw_unknown), int'(lit_flag == 0));
        end
        if (!reset && ((x.vc == 66 && x.hc == 116) ||
                       (x.vc == 60 && x.hc == 122))) begin
          chk("lit_border_rgb", int'(rgb), 'h49);
          chk("lit_border_flag", int'(draw_grid), 1);
        end
        if (!reset && x.vc == 66 &&
            (x.hc == 79 || x.hc == 560 || x.hc == 130)) begin
          chk("lit_out_rgb", int'(rgb), 0);
          chk("lit_out_flags", fl, 0);
        end
      end
    end
  end

  task automatic cyc(input int h, input int v, input bit vo);
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = vo;
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    if (wr_rand) begin
      int x, y;
      wr_valid = ($urandom_range(0, 3) == 0);
      x = $urandom_range(0, 39);
      y = $urandom_range(0, 39);
      if (oob_rand && $urandom_range(0, 7) == 0) x = $urandom_range(40, 63);
      if (oob_rand && $urandom_range(0, 7) == 0) y = $urandom_range(40, 63);
      if (x == 3 && y == 5) x = 4;
      wr_x    = 6'(x);
      wr_y    = 6'(y);
      wr_type = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int vmax);
    for (int v = 0; v <= vmax; v++) begin
      cyc(0, v, 0);
      if (v % 12 == 6 || v == 60) begin
        for (int h = 78; h <= 561; h++) begin
          bit vo;
          if (v == 66 && h == 130) vo = 0;
          else if (h >= 110 && h <= 129) vo = 1;
          else vo = ($urandom_range(0, 15) != 0);
          cyc(h, v, vo);
        end
      end
    end
    wr_valid = 0;
    for (int i = 0; i < 3; i++) cyc(700, 600, 0);
  endtask

  task automatic wr_one(input int x, input int y, input int t, input bit creq);
    wr_valid  = 1;
    wr_x      = 6'(x);
    wr_y      = 6'(y);
    wr_type   = 2'(t);
    clear_req = creq;
    cyc(700, 600, 0);
    wr_valid  = 0;
    clear_req = 0;
  endtask

  task automatic count_busy(input int req_at, output int n);
    n = 0;
    while (clear_busy && n < 5000) begin
      if (n == req_at) clear_req = 1;
      cyc(700, 600, 0);
      clear_req = 0;
      n++;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) cyc(700, 600, 0);
    reset = 0;
    count_busy(-1, n);
    chk("reset_clear_len", n, 1600);

    lit_rgb = 0; lit_flag = 0;
    frame(479);

    wr_one(3, 5, 1, 0);
    lit_rgb = 'hE0; lit_flag = 1;
    frame(90);

    wr_one(3, 5, 2, 0);
    wr_one(40, 3, 1, 0);
    wr_one(7, 45, 1, 0);
    wr_one(63, 63, 3, 0);
    lit_rgb = 'h1C; lit_flag = 2;
    wr_rand = 1; oob_rand = 1;
    frame(479);
    wr_rand = 0; oob_rand = 0;
    wr_valid = 0;

    wr_one(3, 5, 1, 1);
    count_busy(800, n);
    chk("clear_len_rereq", n, 1600);
    lit_rgb = 0; lit_flag = 0;
    frame(90);

    wr_one(3, 5, 2, 1);
    for (int i = 0; i < 700; i++) cyc(700, 600, 0);
    reset = 1;
    for (int i = 0; i < 3; i++) cyc(700, 600, 0);
    reset = 0;
    count_busy(-1, n);
    chk("clear_len_after_reset", n, 1600);
    frame(90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/astar_grid_renderer.md
Name: astar_grid_renderer

Overview:
Display-side consumer of the A* search engine's results. Holds a 40x40 cell-state map (free / obstacle / path / explored) that the search engine writes through a valid/ready port. Converts the VGA timing generator's hcount/vcount into grid coordinates and emits per-pixel draw flags and 8-bit RGB for a fixed 12-pixel-per-cell grid. The VGA syncs are delayed to stay aligned with the pixel outputs.

Parameters:
GRID_N, 40, cells per side; valid coordinates are 0..GRID_N-1.
CELL_PX, 12, pixel pitch of one cell in both axes.
X_OFF, 80, first hcount of grid column 0.
Y_OFF, 0, first vcount of grid row 0.

Ports:
clk  in  1  pixel clock; hcount advances by one per clk.
reset  in  1  reset, asynchronous, active-high.
hcount  in  10  horizontal pixel counter from the VGA timing generator.
vcount  in  10  vertical line counter from the VGA timing generator.
video_on  in  1  visible-area flag.
hsync_in  in  1  raw horizontal sync, active-low.
vsync_in  in  1  raw vertical sync, active-low.
wr_valid  in  1  cell write request.
wr_ready  out  1  write accepted when wr_valid && wr_ready.
wr_x  in  6  cell column.
wr_y  in  6  cell row.
wr_type  in  2  cell type: 0 FREE, 1 OBSTACLE, 2 PATH, 3 EXPLORED.
clear_req  in  1  single-cycle pulse; starts a clear of the whole map to FREE.
clear_busy  out  1  high while a clear is in progress.
hsync_out  out  1  hsync_in delayed by 2 cycles.
vsync_out  out  1  vsync_in delayed by 2 cycles.
gridx  out  6  cell column of the rendered pixel.
gridy  out  6  cell row of the rendered pixel.
draw_grid  out  1  pixel lies on a cell border.
draw_obstacle  out  1  pixel lies in an OBSTACLE cell.
draw_path  out  1  pixel lies in a PATH cell.
draw_unknown  out  1  pixel lies in a FREE cell.
rgb  out  8  pixel colour, RRRGGGBB.

Behaviour:
- Storage: GRID_N*GRID_N x 2-bit dual-port map, address = y*GRID_N + x.
  - One write port, shared by the write handshake and the clear engine.
  - One read port, used by the renderer.
  - A read and a write to the same cell in the same cycle returns the old value.
- Control FSM states:
  - CLEAR: writes FREE to address clr_addr, then increments clr_addr. After writing address GRID_N*GRID_N-1 (1599), moves to IDLE. Takes exactly 1600 cycles.
  - IDLE: wr_ready=1. Accepts one write per cycle. clear_req moves the FSM to CLEAR with clr_addr=0.
- clear_busy = (state == CLEAR). wr_ready = (state == IDLE).
- clear_req while in CLEAR is ignored and does not restart the count.
- clear_req together with wr_valid in IDLE: the write is committed, then CLEAR starts on the next cycle.
- A handshake with wr_x >= GRID_N or wr_y >= GRID_N is accepted (ready honoured) and discarded; the map is unchanged.
- Reset: state=CLEAR, clr_addr=0, so every reset, including one asserted mid-clear, restarts a full clear. Output reset values:
  - rgb=0, gridx=0, gridy=0, all draw_*=0.
  - hsync_out=1, vsync_out=1.
  - wr_ready=0, clear_busy=1.
- Coordinate tracking (no dividers):
  - Column: px_cnt/col reset to 0 when hcount == X_OFF. Otherwise px_cnt increments and wraps at CELL_PX-1, and col increments on each wrap.
  - Row: updated once per line when hcount == 0. row_px/row reset to 0 when vcount == Y_OFF. Otherwise row_px increments and wraps at CELL_PX-1, and row increments on each wrap.
- in_grid = video_on && X_OFF <= hcount < X_OFF+GRID_N*CELL_PX && Y_OFF <= vcount < Y_OFF+GRID_N*CELL_PX.
- Pipeline, latency 2 clk:
  - Stage 1: compute coordinates, in_grid and the border flag; issue the map read.
  - Stage 2: register gridx, gridy, the draw_* flags and rgb.
  - Syncs pass through a matching 2-stage delay.
- Pixel priority:
  - !in_grid: rgb=0x00, all draw_*=0. gridx/gridy hold their last in-grid value.
  - Border (px_cnt==0 or row_px==0): draw_grid=1, rgb=0x49.
  - OBSTACLE: draw_obstacle=1, rgb=0xE0.
  - PATH: draw_path=1, rgb=0x1C.
  - EXPLORED: rgb=0x03, no draw_* flag asserted.
  - FREE: draw_unknown=1, rgb=0x00.
- At most one draw_* is high in any cycle.
- Rendering continues during CLEAR; cells show their partially cleared contents.

Test Plan:
- Release reset: clear_busy=1 and wr_ready=0 for exactly 1600 cycles, then wr_ready=1. A full frame scan shows draw_unknown on every in-grid non-border pixel.
- Write (x=3, y=5, OBSTACLE), then present hcount=122, vcount=66 -> 2 cycles later gridx=3, gridy=5, draw_obstacle=1, rgb=0xE0. Repeat with PATH -> draw_path=1, rgb=0x1C.
- hcount=116, vcount=66 (column border) and hcount=122, vcount=60 (row border) -> draw_grid=1, rgb=0x49. hcount=79 or 560, or video_on=0 -> rgb=0x00, all draw_* low.
- Write with wr_x=40 or wr_y=45 -> handshake completes and a full-map readback is unchanged. Toggle hsync_in/vsync_in -> hsync_out/vsync_out follow exactly 2 cycles later.
- clear_req in IDLE after writing (3,5) -> wr_ready low for 1600 cycles, then (3,5) renders FREE. A second clear_req at cycle 800 of the clear -> total busy time still 1600 cycles.
- Assert reset at cycle 700 of a clear, hold 3 cycles, release -> clear_busy high for a fresh 1600 cycles. All outputs hold their reset values during reset.
